// File: rtl/sete_segmentos_mux.sv
// Multiplexed N-digit hex seven-segment driver with leading-zero blanking.
// Optional per-digit blink is compiled in with SETE_SEGMENTOS_MUX_BLINK_EN.
module sete_segmentos_mux #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  load,
    input  logic                  lz_blank,
    input  logic [N_DIGITS-1:0]   blink,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   dig_en,
    output logic                  frame_tick
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [4*N_DIGITS-1:0] shadow;
    logic [SW-1:0]         scan_cnt;
    logic [IW-1:0]         idx;
    logic                  scan_tc;
    logic                  idx_wrap;
    logic [N_DIGITS-1:0]   zero_from;
    logic [N_DIGITS-1:0]   sel_onehot;
    logic [3:0]            cur_digit;
    logic                  cur_zero;
    logic                  cur_blink;
    logic                  lz_off;
    logic                  blink_off;

    function automatic logic [6:0] hex_glyph(input logic [3:0] d);
        case (d)
            4'h0: hex_glyph = 7'h40;
            4'h1: hex_glyph = 7'h79;
            4'h2: hex_glyph = 7'h24;
            4'h3: hex_glyph = 7'h30;
            4'h4: hex_glyph = 7'h19;
            4'h5: hex_glyph = 7'h12;
            4'h6: hex_glyph = 7'h02;
            4'h7: hex_glyph = 7'h78;
            4'h8: hex_glyph = 7'h00;
            4'h9: hex_glyph = 7'h10;
            4'hA: hex_glyph = 7'h08;
            4'hB: hex_glyph = 7'h03;
            4'hC: hex_glyph = 7'h46;
            4'hD: hex_glyph = 7'h21;
            4'hE: hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    assign scan_tc  = (scan_cnt == SW'(SCAN_DIV - 1));
    assign idx_wrap = scan_tc && (idx == IW'(N_DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= value;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_tc) begin
            scan_cnt <= '0;
            idx      <= idx_wrap ? '0 : idx + IW'(1);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    // zero_from[i]: digit i and every digit above it are zero
    always_comb begin
        logic above_zero;
        above_zero = 1'b1;
        zero_from  = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            above_zero   = above_zero & (shadow[4*i +: 4] == 4'h0);
            zero_from[i] = above_zero;
        end
    end

    always_comb begin
        cur_digit  = 4'h0;
        cur_zero   = 1'b0;
        cur_blink  = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit     = shadow[4*i +: 4];
                cur_zero      = zero_from[i];
                cur_blink     = blink[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Digit 0 is never blanked so an all-zero value still shows "0".
    assign lz_off = lz_blank && (idx != '0) && cur_zero;

`ifdef SETE_SEGMENTOS_MUX_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] frame_cnt;
    logic          phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == BW'(BLINK_DIV - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + BW'(1);
            end
        end
    end

    assign blink_off = phase && cur_blink;
`else
    logic unused_blink;
    assign unused_blink = cur_blink;
    assign blink_off    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= 7'h7F;
            dig_en     <= '1;
            frame_tick <= 1'b0;
        end else begin
            seg        <= (lz_off || blink_off) ? 7'h7F : hex_glyph(cur_digit);
            dig_en     <= ~sel_onehot;
            frame_tick <= idx_wrap;
        end
    end

endmodule
